// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze control for pipeline stage register load/init pins.
// Optional performance counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int WAIT_W       = 8
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,parameter int CNT_WIDTH   = 32
`endif
)(
  input  logic clk,
  input  logic rst,
  input  logic hazard,
  input  logic branch_taken,
  input  logic mem_req,
  input  logic mem_ready,
  output logic pc_load,
  output logic if_id_load,
  output logic if_id_init,
  output logic id_ex_load,
  output logic id_ex_init,
  output logic ex_mem_load,
  output logic ex_mem_init,
  output logic mem_wb_load,
  output logic mem_wb_init,
  output logic frozen,
  output logic mem_err
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,output logic [CNT_WIDTH-1:0] stall_cnt
  ,output logic [CNT_WIDTH-1:0] flush_cnt
  ,output logic [CNT_WIDTH-1:0] freeze_cnt
`endif
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_e;
  localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0] flush_q, flush_d;
  logic err_q, err_d;
  logic frz, flsh, stl, run;
  // Freeze outranks flush, flush outranks the load-use bubble.
  assign frz  = !rst && (state_q == MEM_WAIT ? !mem_ready : mem_req && !mem_ready);
  assign run  = !rst && !frz;
  assign flsh = run && (branch_taken || state_q == FLUSH);
  assign stl  = run && !flsh && hazard;
  assign pc_load     = run && !stl;
  assign if_id_load  = run && !flsh && !stl;
  assign if_id_init  = rst || flsh;
  assign id_ex_load  = run && !flsh && !stl;
  assign id_ex_init  = rst || flsh || stl;
  assign ex_mem_load = run;
  assign ex_mem_init = rst;
  assign mem_wb_load = run;
  assign mem_wb_init = rst;
  assign frozen      = frz;
  assign mem_err     = err_q;
  always_comb begin
    state_d = frz ? (state_q == FLUSH ? FLUSH : MEM_WAIT)
            : !flsh ? RUN
            : branch_taken ? (FLUSH_CYCLES > 1 ? FLUSH : RUN)
            : (flush_q == 4'd1 ? RUN : FLUSH);
    flush_d = frz ? flush_q : !flsh ? 4'd0 : branch_taken ? FLUSH_RELOAD : flush_q - 4'd1;
    wait_d  = !frz ? '0 : &wait_q ? wait_q : wait_q + 1'b1;
    err_d   = err_q || (frz && wait_d >= TIMEOUT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      flush_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      stall_cnt  <= stall_cnt + CNT_WIDTH'(stl);
      flush_cnt  <= flush_cnt + CNT_WIDTH'(flsh);
      freeze_cnt <= freeze_cnt + CNT_WIDTH'(frz);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random stimulus against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int FC = 2;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b1;
  logic pc_load, if_id_load, if_id_init, id_ex_load, id_ex_init;
  logic ex_mem_load, ex_mem_init, mem_wb_load, mem_wb_init, frozen, mem_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, freeze_cnt;
  int m_stall = 0, m_flush = 0, m_freeze = 0;
`endif
  int checks = 0, passes = 0;
  int flush_left = 0, waits = 0;
  bit in_wait = 0, err = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_init(if_id_init),
    .id_ex_load(id_ex_load), .id_ex_init(id_ex_init),
    .ex_mem_load(ex_mem_load), .ex_mem_init(ex_mem_init),
    .mem_wb_load(mem_wb_load), .mem_wb_init(mem_wb_init),
    .frozen(frozen), .mem_err(mem_err)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Vector order: pc_load, if_id_load/init, id_ex_load/init, ex_mem_load/init, mem_wb_load/init, frozen
  task automatic step(input bit r, input bit h, input bit b, input bit q, input bit y);
    bit frz, fl, st;
    logic [9:0] exp;
    rst = r; hazard = h; branch_taken = b; mem_req = q; mem_ready = y;
    frz = !r && (in_wait ? !y : (q && !y));
    fl  = !r && !frz && (b || flush_left > 0);
    st  = !r && !frz && !fl && h;
    exp = r ? 10'b0010101010 : frz ? 10'b0000000001 : fl ? 10'b1010110100
        : st ? 10'b0000110100 : 10'b1101010100;
    @(negedge clk);
    check("ctrl", 32'({pc_load, if_id_load, if_id_init, id_ex_load, id_ex_init,
                       ex_mem_load, ex_mem_init, mem_wb_load, mem_wb_init, frozen}), 32'(exp));
    check("mem_err", 32'(mem_err), 32'(err));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);
    check("freeze_cnt", freeze_cnt, m_freeze);
`endif
    @(posedge clk);
    if (r) begin
      flush_left = 0; waits = 0; in_wait = 0; err = 0;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      m_stall = 0; m_flush = 0; m_freeze = 0;
`endif
    end else begin
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      m_stall += int'(st); m_flush += int'(fl); m_freeze += int'(frz);
`endif
      if (frz) begin
        in_wait = (flush_left == 0);
        waits = (waits < 255) ? waits + 1 : 255;
        if (waits >= TO) err = 1;
      end else begin
        in_wait = 0; waits = 0;
        if (fl) flush_left = b ? FC - 1 : flush_left - 1;
      end
    end
    #1;
  endtask

  initial begin
    repeat (2) step(1, 1, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (2) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 5);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the load/init control pins of the pipeline stage registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB), which are built from the team's Register/Register_init cells.
- Arbitrates three conditions each cycle: a load-use hazard (stall plus bubble), a taken branch (flush), and a multi-cycle data-memory access (full-pipeline freeze).
- Sits beside the hazard unit and the EX-stage branch logic in the ARM core top level.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID and ID/EX are cleared after a taken branch (1..15).
- MEM_TIMEOUT, 255, maximum freeze cycles before mem_err is raised (1..2^WAIT_W-1).
- WAIT_W, 8, width of the internal memory-wait counter.
- CNT_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- hazard  in  1  load-use hazard detected for the instruction in ID
- branch_taken  in  1  taken branch/jump resolved in EX
- mem_req  in  1  instruction in MEM accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_load  out  1  PC register load
- if_id_load, if_id_init  out  1 each  IF/ID load / clear
- id_ex_load, id_ex_init  out  1 each  ID/EX load / clear
- ex_mem_load, ex_mem_init  out  1 each  EX/MEM load / clear
- mem_wb_load, mem_wb_init  out  1 each  MEM/WB load / clear
- frozen  out  1  pipeline frozen waiting on memory
- mem_err  out  1  sticky: memory wait exceeded MEM_TIMEOUT

Behaviour:
- Synchronous reset, active-high, one clock: state=RUN, wait counter=0, flush counter=0, mem_err=0.
- While rst=1, outputs are overridden combinationally: all *_load=0, all *_init=1, frozen=0.
- States: RUN, MEM_WAIT, FLUSH. State and counters are registered. Control outputs are combinational from state and inputs (zero latency).
- Priority in RUN, highest first:
  1. Memory stall, when mem_req=1 and mem_ready=0: all loads=0, all inits=0, frozen=1. Next state MEM_WAIT, wait counter=1.
  2. branch_taken=1: pc_load=1, if_id_init=1, id_ex_init=1; ex_mem_load and mem_wb_load=1. Next state FLUSH if FLUSH_CYCLES>1, with flush counter=FLUSH_CYCLES-1; otherwise RUN.
  3. hazard=1: pc_load=0, if_id_load=0, id_ex_init=1; ex_mem_load and mem_wb_load=1. Stay in RUN.
  4. Otherwise all loads=1 and all inits=0.
- MEM_WAIT:
  - While mem_ready=0: freeze exactly as in the RUN memory stall. Wait counter increments and saturates at 2^WAIT_W-1.
  - When the counter reaches MEM_TIMEOUT, mem_err is set. mem_err stays set until rst; the freeze continues.
  - The cycle mem_ready=1: the freeze is released and branch_taken/hazard are evaluated with RUN priorities 2–4. Next state is FLUSH or RUN accordingly; the wait counter clears.
  - branch_taken and hazard have no effect while frozen.
- FLUSH:
  - pc_load=1, if_id_init=1, id_ex_init=1; other loads=1.
  - Flush counter decrements each cycle; return to RUN when it reaches 0.
  - A memory stall in FLUSH freezes the pipeline and pauses the counter; the state stays FLUSH with frozen=1.
  - A new branch_taken in FLUSH reloads the counter to FLUSH_CYCLES-1.
- Any init=1 on a stage takes precedence over its load. An output never has load=1 and init=1 together except where stated above.
- rst asserted mid-freeze or mid-flush aborts immediately to RUN on the next edge.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined: adds outputs stall_cnt, flush_cnt, freeze_cnt (each CNT_WIDTH, out). They count cycles of hazard stall, flush (branch cycle plus FLUSH-state cycles), and frozen=1 respectively. Each wraps modulo 2^CNT_WIDTH and clears on rst.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles with hazard=1 → all loads=0, all inits=1; after release with idle inputs → all loads=1, inits=0, frozen=0, mem_err=0.
- Load-use: hazard=1 for 1 cycle → that cycle pc_load=0, if_id_load=0, id_ex_init=1, ex_mem_load=1; next cycle all loads=1.
- Branch with FLUSH_CYCLES=2: branch_taken=1 for 1 cycle → if_id_init=id_ex_init=1 for exactly 2 cycles, pc_load=1 throughout; hazard=1 in the branch cycle is ignored.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → frozen=1 and all loads=0 for 3 cycles; released in cycle 4; branch_taken=1 during the freeze has no effect until the release cycle.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 → mem_err rises on the 4th wait cycle, stays 1 after mem_ready=1, clears only on rst.
- Perf with PIPE_HAZARD_CTRL_PERF_EN defined: 2 hazard cycles, 1 branch (FLUSH_CYCLES=1), 3 frozen cycles → stall_cnt=2, flush_cnt=1, freeze_cnt=3.
